// File: rtl/deserializer.sv
// rtl/deserializer.sv - byte-to-256-bit word deserializer with early end and backpressure
//
// Collects bytes into a big-endian, right-aligned word of up to 32 bytes.
// A word ends when its byte count reaches the length sampled on its first
// byte, or on a byte flagged in_last. The finished word is held on out
// until the downstream stage takes it. A byte can be accepted on the same
// edge that hands the word over, so back-to-back streaming has no gaps.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   in         incoming byte
//   in_valid   in holds a byte this cycle
//   in_last    with in_valid: this byte ends the current word
//   in_ready   the byte on in is accepted this cycle
//   length     bytes per word (0 or >32 means 32), sampled on a word's first byte
//   out        assembled word, right-aligned
//   out_len    number of valid bytes in out (1..32)
//   out_valid  out/out_len hold a complete word
//   out_ready  downstream consumes the word this cycle

module deserializer (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic [5:0]   length,
  output logic [255:0] out,
  output logic [5:0]   out_len,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_rst_done;
  logic [5:0]     r_count;
  logic [5:0]     r_len;
  // Only 31 bytes ever need to wait here: the 32nd byte completes the word
  // and goes straight to the output register.
  logic [247:0]   r_shift;
  logic [255:0]   r_out;
  logic [5:0]     r_out_len;

  logic           w_accept;
  logic           w_first;
  logic           w_done;
  logic [5:0]     w_len_in;
  logic [5:0]     w_target;
  logic [5:0]     w_count_inc;
  logic [247:0]   w_base;
  logic [255:0]   w_word;

  // r_rst_done keeps in_ready low during reset and lets it rise on the
  // first edge after release.
  assign in_ready  = r_rst_done & ((r_state == COLLECT) | out_ready);
  assign w_accept  = in_valid & in_ready;

  // In FULL a byte is only accepted together with the handover, so any
  // accepted byte in FULL starts a new word.
  assign w_first     = (r_state == FULL) | (r_count == 6'd0);
  assign w_len_in    = ((length == 6'd0) || (length > 6'd32)) ? 6'd32 : length;
  assign w_target    = w_first ? w_len_in : r_len;
  assign w_count_inc = (w_first ? 6'd0 : r_count) + 6'd1;
  assign w_base      = w_first ? '0 : r_shift;
  assign w_word      = {w_base, in};
  assign w_done      = w_accept & (in_last | (w_count_inc == w_target));

  assign out       = r_out;
  assign out_len   = r_out_len;
  assign out_valid = (r_state == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_done ? FULL : COLLECT;
    end else if ((r_state == FULL) && out_ready) begin
      w_state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_done <= 1'b0;
      r_count    <= 6'd0;
      r_len      <= 6'd0;
      r_shift    <= '0;
      r_out      <= '0;
      r_out_len  <= 6'd0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        if (w_done) begin
          r_out     <= w_word;
          r_out_len <= w_count_inc;
          r_count   <= 6'd0;
        end else begin
          r_count   <= w_count_inc;
          r_shift   <= w_word[247:0];
          r_len     <= w_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed self-checking bench for deserializer

module tb_deserializer;

  logic         clk;
  logic         reset;
  logic [7:0]   in;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [5:0]   length;
  logic [255:0] out;
  logic [5:0]   out_len;
  logic         out_valid;
  logic         out_ready;

  int n_vec;
  int n_err;

  logic [255:0] full_word;
  logic [255:0] exp_word;
  logic [7:0]   b;
  logic [5:0]   lv;

  deserializer dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .length    (length),
    .out       (out),
    .out_len   (out_len),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] bv, input logic last, input logic [5:0] len);
    in       = bv;
    in_last  = last;
    length   = len;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic consume();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_valid", out_valid, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    full_word = 256'h9b26a9260ed12149a6cd6fa17c862b1d5066f8cb54fdae4a9ad7dfb3c4f34076;
    reset = 1'b0; in = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    length = 6'd0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_len", out_len, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    chk("ready_after_rst", in_ready, 1);

    // full 32-byte word
    for (int k = 0; k < 32; k++) begin
      b = full_word[8*(31-k) +: 8];
      send_byte(b, 1'b0, 6'd32);
      if (k == 30) chk("full_not_yet", out_valid, 0);
    end
    in_valid = 1'b0;
    chk("full_out", out, full_word);
    chk("full_len", out_len, 6'd32);
    chk("full_valid", out_valid, 1);
    chk("full_hold_ready", in_ready, 0);
    consume();
    chk("out_kept_after_consume", out, full_word);

    // short word, with a stray in_last while in_valid is low
    send_byte(8'hde, 1'b0, 6'd4);
    send_byte(8'had, 1'b0, 6'd4);
    in_valid = 1'b0;
    in_last  = 1'b1;
    tick();
    send_byte(8'hbe, 1'b0, 6'd4);
    send_byte(8'hef, 1'b0, 6'd4);
    in_valid = 1'b0;
    chk("short_out", out, 256'hdeadbeef);
    chk("short_len", out_len, 6'd4);
    chk("short_valid", out_valid, 1);
    consume();

    // early end via in_last
    send_byte(8'h12, 1'b0, 6'd32);
    in_valid = 1'b0;
    chk("early_mid_valid", out_valid, 0);
    chk("early_mid_out_stable", out, 256'hdeadbeef);
    send_byte(8'h34, 1'b1, 6'd32);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("early_out", out, 256'h1234);
    chk("early_len", out_len, 6'd2);
    chk("early_valid", out_valid, 1);
    consume();

    // backpressure with in_valid held high
    send_byte(8'haa, 1'b0, 6'd4);
    send_byte(8'hbb, 1'b0, 6'd4);
    send_byte(8'hcc, 1'b0, 6'd4);
    send_byte(8'hdd, 1'b0, 6'd4);
    in = 8'h11; in_last = 1'b0; length = 6'd4; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_ready", in_ready, 0);
      chk("bp_out", out, 256'haabbccdd);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_handover_valid", out_valid, 0);
    send_byte(8'h22, 1'b0, 6'd1);
    send_byte(8'h33, 1'b0, 6'd1);
    send_byte(8'h44, 1'b0, 6'd1);
    in_valid = 1'b0;
    chk("bp_next_out", out, 256'h11223344);
    chk("bp_next_len", out_len, 6'd4);
    consume();

    // length 0 and 40 both mean 32
    for (int p = 0; p < 2; p++) begin
      lv = (p == 0) ? 6'd0 : 6'd40;
      exp_word = '0;
      for (int k = 0; k < 32; k++) begin
        b = 8'(k);
        send_byte(b, 1'b0, lv);
        exp_word = {exp_word[247:0], b};
        if (k == 30) chk("len_clamp_not_yet", out_valid, 0);
      end
      in_valid = 1'b0;
      chk("len_clamp_out", out, exp_word);
      chk("len_clamp_len", out_len, 6'd32);
      consume();
    end

    // length changes mid-word are ignored
    send_byte(8'h01, 1'b0, 6'd4);
    send_byte(8'h02, 1'b0, 6'd2);
    send_byte(8'h03, 1'b0, 6'd1);
    in_valid = 1'b0;
    chk("len_change_mid_valid", out_valid, 0);
    send_byte(8'h04, 1'b0, 6'd0);
    in_valid = 1'b0;
    chk("len_change_out", out, 256'h01020304);
    chk("len_change_len", out_len, 6'd4);
    consume();

    // length 1 streaming: one word per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b = 8'hc0 + 8'(k);
      send_byte(b, 1'b0, 6'd1);
      chk("stream_valid", out_valid, 1);
      chk("stream_out", out, {248'b0, b});
      chk("stream_len", out_len, 6'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", out_valid, 0);
    out_ready = 1'b0;

    // reset after 17 of 32 bytes
    for (int k = 0; k < 17; k++) begin
      b = full_word[8*(31-k) +: 8];
      send_byte(b, 1'b0, 6'd32);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_out", out, 0);
    chk("midrst_len", out_len, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int w = 0; w < 5 && !in_ready; w++) tick();
    chk("midrst_ready_back", in_ready, 1);
    for (int k = 0; k < 32; k++) begin
      b = full_word[8*(31-k) +: 8];
      send_byte(b, 1'b0, 6'd32);
    end
    in_valid = 1'b0;
    chk("midrst_fresh_out", out, full_word);
    chk("midrst_fresh_len", out_len, 6'd32);
    chk("midrst_fresh_valid", out_valid, 1);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
